// File: rtl/clk_en_gen_multi.sv
// clk_en_gen_multi: lock-filtered multi-channel clock-enable/duty generator (CLK_EN_GEN_LOCK_CNT_EN adds lock_loss_cnt)
module clk_en_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 10,
  parameter int LOCK_FILT = 16,
  parameter int DEF_RATIO = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pll_lock,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_ratio,
  input  logic [DIV_W-1:0]  cfg_duty,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              cfg_apply,
  input  logic              clr_lost,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_lvl,
  output logic              running,
  output logic              lock_lost
`ifdef CLK_EN_GEN_LOCK_CNT_EN
  ,
  output logic [15:0]       lock_loss_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, FILT, RUN, RELOAD} state_t;
  localparam int FW = $clog2(LOCK_FILT + 1);
  state_t state, state_n;
  logic lock_m, lock_s, apply_pend, drop, gate, load;
  logic [FW-1:0] filt_cnt;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = lock_s ? FILT : IDLE;
      FILT:    state_n = !lock_s ? IDLE : (filt_cnt == FW'(LOCK_FILT)) ? RUN : FILT;
      RUN:     state_n = !lock_s ? IDLE : apply_pend ? RELOAD : RUN;
      default: state_n = lock_s ? RUN : IDLE;
    endcase
    drop = (state == RUN || state == RELOAD) && !lock_s;
    gate = state == RUN && state_n == RUN;
    load = state == RELOAD || (state == FILT && state_n == RUN && apply_pend);
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      filt_cnt <= '0;
      apply_pend <= 1'b0;
      running <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
      state <= state_n;
      filt_cnt <= state_n != FILT ? '0 : state == FILT ? filt_cnt + FW'(1) : FW'(1);
      apply_pend <= cfg_apply | (apply_pend & ~load);
      running <= state_n == RUN;
      lock_lost <= drop | (lock_lost & ~clr_lost);
    end
  end
`ifdef CLK_EN_GEN_LOCK_CNT_EN
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      lock_loss_cnt <= '0;
    else if (drop)
      lock_loss_cnt <= lock_loss_cnt == 16'hFFFF ? lock_loss_cnt : lock_loss_cnt + 16'd1;
    else if (clr_lost)
      lock_loss_cnt <= '0;
  end
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] sh_ratio, sh_duty, sh_phase, ratio, duty, phase, cnt, ratio_e, phase_e;
    logic en, lvl;
    always_comb begin
      ratio_e = ratio == '0 ? DIV_W'(1) : ratio;
      phase_e = phase > ratio_e - DIV_W'(1) ? ratio_e - DIV_W'(1) : phase;
    end
    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        sh_ratio <= DIV_W'(DEF_RATIO);
        sh_duty <= DIV_W'(DEF_RATIO / 2);
        sh_phase <= '0;
        ratio <= DIV_W'(DEF_RATIO);
        duty <= DIV_W'(DEF_RATIO / 2);
        phase <= '0;
        cnt <= '0;
        en <= 1'b0;
        lvl <= 1'b0;
      end else begin
        if (cfg_wr && int'(cfg_ch) == i) begin
          sh_ratio <= cfg_ratio;
          sh_duty <= cfg_duty;
          sh_phase <= cfg_phase;
        end
        if (load) begin
          ratio <= sh_ratio;
          duty <= sh_duty;
          phase <= sh_phase;
        end
        cnt <= !gate ? '0 : cnt == ratio_e - DIV_W'(1) ? '0 : cnt + DIV_W'(1);
        en <= gate && cnt == phase_e;
        lvl <= gate && cnt < duty;
      end
    end
    assign clk_en[i] = en;
    assign clk_lvl[i] = lvl;
  end
endmodule

// File: tb/tb_clk_en_gen_multi.sv
// tb_clk_en_gen_multi: directed vector bench for clk_en_gen_multi
module tb_clk_en_gen_multi;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, pll_lock = 1'b1;
  logic cfg_wr = 1'b0, cfg_apply = 1'b0, clr_lost = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [9:0] cfg_ratio = '0, cfg_duty = '0, cfg_phase = '0;
  logic [3:0] clk_en, clk_lvl;
  logic running, lock_lost;
  int checks = 0, failures = 0;
`ifdef CLK_EN_GEN_LOCK_CNT_EN
  logic [15:0] lock_loss_cnt;
`endif
  clk_en_gen_multi dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_ratio(cfg_ratio), .cfg_duty(cfg_duty),
    .cfg_phase(cfg_phase), .cfg_apply(cfg_apply), .clr_lost(clr_lost),
    .clk_en(clk_en), .clk_lvl(clk_lvl), .running(running), .lock_lost(lock_lost)
`ifdef CLK_EN_GEN_LOCK_CNT_EN
    , .lock_loss_cnt(lock_loss_cnt)
`endif
  );
  always #5 sys_clk = ~sys_clk;
  typedef struct {
    logic [2:0] ch;
    logic [9:0] ratio, duty, phase;
    int obs;
    logic [15:0] en, lvl;
  } vec_t;
  vec_t tbl [8];
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic collect(input int ch, input int n, output logic [15:0] en, output logic [15:0] lvl);
    en = '0;
    lvl = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      en[k] = clk_en[ch];
      lvl[k] = clk_lvl[ch];
    end
  endtask
  task automatic write_apply(input logic [2:0] ch, input logic [9:0] r, input logic [9:0] d, input logic [9:0] p);
    cfg_wr = 1'b1;
    cfg_apply = 1'b1;
    cfg_ch = ch;
    cfg_ratio = r;
    cfg_duty = d;
    cfg_phase = p;
    tick();
    cfg_wr = 1'b0;
    cfg_apply = 1'b0;
  endtask
  initial begin
    logic [15:0] en, lvl;
    tbl[0] = '{3'd0, 10'd2, 10'd1, 10'd0, 0, 16'h5555, 16'h5555};
    tbl[1] = '{3'd1, 10'd5, 10'd2, 10'd3, 1, 16'h2108, 16'h8C63};
    tbl[2] = '{3'd2, 10'd0, 10'd0, 10'd0, 2, 16'hFFFF, 16'h0000};
    tbl[3] = '{3'd3, 10'd1, 10'd1, 10'd5, 3, 16'hFFFF, 16'hFFFF};
    tbl[4] = '{3'd2, 10'd4, 10'd7, 10'd9, 2, 16'h8888, 16'hFFFF};
    tbl[5] = '{3'd0, 10'd3, 10'd1, 10'd0, 0, 16'h9249, 16'h9249};
    tbl[6] = '{3'd6, 10'd7, 10'd3, 10'd2, 2, 16'h8888, 16'hFFFF};
    tbl[7] = '{3'd1, 10'd5, 10'd2, 10'd3, 0, 16'h9249, 16'h9249};
    tick(2);
    check("rst_en", clk_en, 4'h0);
    check("rst_lvl", clk_lvl, 4'h0);
    check("rst_running", running, 1'b0);
    check("rst_lost", lock_lost, 1'b0);
    sys_rst_n = 1'b1;
    tick(18);
    check("run_early", running, 1'b0);
    tick();
    check("run_start", running, 1'b1);
    collect(0, 8, en, lvl);
    check("def_ch0_en", en, 16'h0055);
    check("def_ch0_lvl", lvl, 16'h0055);
    collect(3, 8, en, lvl);
    check("def_ch3_en", en, 16'h0055);
    sys_rst_n = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    tick(10);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick(8);
    check("glitch_run_e19", running, 1'b0);
    tick(10);
    check("glitch_run_e29", running, 1'b0);
    tick();
    check("glitch_run_e30", running, 1'b1);
    check("glitch_lost", lock_lost, 1'b0);
    for (int v = 0; v < 8; v++) begin
      write_apply(tbl[v].ch, tbl[v].ratio, tbl[v].duty, tbl[v].phase);
      tick();
      check($sformatf("v%0d_reload_en", v), clk_en, 4'h0);
      check($sformatf("v%0d_reload_run", v), running, 1'b0);
      tick();
      collect(tbl[v].obs, 16, en, lvl);
      check($sformatf("v%0d_en", v), en, tbl[v].en);
      check($sformatf("v%0d_lvl", v), lvl, tbl[v].lvl);
    end
    check("pre_drop_lost", lock_lost, 1'b0);
    pll_lock = 1'b0;
    tick(2);
    check("drop1_run_e2", running, 1'b1);
    tick();
    check("drop1_run", running, 1'b0);
    check("drop1_en", clk_en, 4'h0);
    check("drop1_lvl", clk_lvl, 4'h0);
    check("drop1_lost", lock_lost, 1'b1);
`ifdef CLK_EN_GEN_LOCK_CNT_EN
    check("drop1_cnt", lock_loss_cnt, 16'd1);
`endif
    pll_lock = 1'b1;
    tick(19);
    check("relock1_run", running, 1'b1);
    check("relock1_lost", lock_lost, 1'b1);
    pll_lock = 1'b0;
    tick(3);
    check("drop2_run", running, 1'b0);
`ifdef CLK_EN_GEN_LOCK_CNT_EN
    check("drop2_cnt", lock_loss_cnt, 16'd2);
`endif
    write_apply(3'd1, 10'd3, 10'd3, 10'd1);
    pll_lock = 1'b1;
    tick(19);
    check("relock2_run", running, 1'b1);
    collect(1, 8, en, lvl);
    check("idle_apply_en", en, 16'h0092);
    check("idle_apply_lvl", lvl, 16'h00FF);
    check("idle_apply_run", running, 1'b1);
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    check("clr_lost", lock_lost, 1'b0);
`ifdef CLK_EN_GEN_LOCK_CNT_EN
    check("clr_cnt", lock_loss_cnt, 16'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_en_gen_multi.md
Name: clk_en_gen_multi

Overview:
Parametrised successor to the fixed-ratio PLL output wrapper. From one PLL output clock it produces NUM_CH run-time-programmable clock-enable pulses and duty waveforms, each with its own ratio, duty and phase. Channels start only after a filtered PLL lock and restart phase-aligned whenever the configuration is reloaded. It sits between the PLL and the sample-rate-domain DSP logic (ADC capture, filters, decimators).

Parameters:
NUM_CH, 4, number of output channels (1..8)
DIV_W, 10, width of ratio/duty/phase fields
LOCK_FILT, 16, consecutive synchronised lock cycles required before RUN (>=2)
DEF_RATIO, 2, reset value of every channel ratio; reset duty = DEF_RATIO/2, reset phase = 0

Ports:
sys_clk  in  1  single clock (PLL output)
sys_rst_n  in  1  synchronous, active-low reset
pll_lock  in  1  PLL lock, asynchronous to sys_clk
cfg_wr  in  1  write shadow registers of channel cfg_ch
cfg_ch  in  3  channel index; writes with cfg_ch>=NUM_CH are ignored
cfg_ratio  in  DIV_W  divide ratio
cfg_duty  in  DIV_W  high cycles per period
cfg_phase  in  DIV_W  enable-pulse offset within period
cfg_apply  in  1  one-cycle pulse: shadow -> active, aligned restart
clr_lost  in  1  clears lock_lost
clk_en  out  NUM_CH  one-cycle enable per channel period
clk_lvl  out  NUM_CH  duty waveform per channel
running  out  1  high in RUN state
lock_lost  out  1  sticky: lock dropped while in RUN

Behaviour:
- Reset (sys_rst_n=0 at sys_clk edge): state IDLE; all counters 0; clk_en=0, clk_lvl=0, running=0, lock_lost=0; active and shadow regs = defaults; apply_pend=0.
- pll_lock passes a 2-FF synchroniser (lock_s); 2-cycle latency.
- FSM:
  - IDLE: lock_s=1 -> FILT with filter count=1.
  - FILT: lock_s=0 -> IDLE, count cleared. Count reaches LOCK_FILT -> RUN with all channel counters=0.
  - RUN: lock_s=0 -> IDLE (same cycle outputs forced 0 next edge), lock_lost<=1. apply_pend=1 -> RELOAD.
  - RELOAD (1 cycle): active<=shadow for all channels; counters<=0; clk_en=0, clk_lvl=0; apply_pend<=0; -> RUN. If lock_s=0 here, go IDLE, set lock_lost, apply_pend cleared, active still loaded.
- cfg_apply sets apply_pend in any state. In IDLE/FILT, shadow->active happens at the FILT->RUN transition; no RELOAD cycle.
- cfg_wr and cfg_apply in the same cycle: the write lands first, so the written values are included in the apply.
- clr_lost and a lock drop in the same cycle: set wins.
- Effective values: ratio_e = max(ratio,1); phase_e = min(phase, ratio_e-1); duty>=ratio_e -> clk_lvl constantly 1; duty=0 -> constantly 0.
- Per channel in RUN:
  - cnt counts 0..ratio_e-1 and wraps.
  - clk_en registered: =1 when cnt==phase_e, so exactly one pulse per period.
  - clk_lvl registered: =1 when cnt<duty.
  - Outputs lag cnt by one cycle.
  - With ratio_e=1, clk_en is constantly 1.
- All channels share the RUN-entry and RELOAD restart points, so the first clk_en of every channel occurs at cycle 1+phase_e after counters clear (cycle 0 = first RUN cycle).
- running = (state==RUN), registered.
- No arithmetic overflow: counters are DIV_W wide; ratio up to 2^DIV_W-1.

Optional Feature:
CLK_EN_GEN_LOCK_CNT_EN
- Defined: adds output port lock_loss_cnt[15:0]. It increments on every RUN/RELOAD->IDLE lock drop, saturates at 16'hFFFF, resets to 0, and clears on clr_lost.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, pll_lock=1 from cycle 0, LOCK_FILT=16 -> running=1 at cycle 2+16 (+1 reg); ch0 clk_en period 2, clk_lvl 1 high / 1 low.
- Write ch1 ratio=5 duty=2 phase=3, apply -> one RELOAD cycle with clk_en=0; then ch1 clk_en every 5 cycles, first pulse 4 cycles after RELOAD; clk_lvl pattern 11000. ch0 restarts aligned.
- Channel with ratio=0 and ratio=1 -> clk_en constantly 1; duty=7 with ratio=4 -> clk_lvl constantly 1; phase=9 with ratio=4 -> pulse at cnt 3.
- pll_lock pulses low for 1 cycle during FILT at count 10 -> back to IDLE; full 16 cycles required again; lock_lost stays 0.
- pll_lock drops in RUN -> outputs 0 within 3 cycles, lock_lost=1, held through relock; clr_lost -> 0. With macro: lock_loss_cnt=1, then 2 after a second drop.
- cfg_wr to cfg_ch=6 with NUM_CH=4 -> no change; cfg_wr + cfg_apply same cycle -> new value active after RELOAD.
